// File: rtl/proc_mem_arb_pkg.sv
// proc_mem_arb_pkg -- shared definitions for the arbitrated word memory.
//   req_type_e : request type encoding (READ=0, WRITE=1)
//   ADDR_W     : fixed byte-address width
//   ptr_w()    : round-robin pointer width for a given channel count
//   idx_w()    : word-index width for a given storage depth
package proc_mem_arb_pkg;

  typedef enum logic {
    REQ_READ  = 1'b0,
    REQ_WRITE = 1'b1
  } req_type_e;

  localparam int ADDR_W   = 32;
  localparam int BYTE_LSB = 2;  // word-aligned: byte offset bits are dropped

  // Pointer/index width; a single channel still needs one bit to exist.
  function automatic int ptr_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int idx_w(input int num_words);
    return $clog2(num_words);
  endfunction

endpackage

// File: rtl/proc_mem_rr_arb.sv
// proc_mem_rr_arb -- round-robin grant with rotating priority pointer.
//   clk  : clock
//   rst  : synchronous active-low reset (pointer -> 0, no grant while low)
//   req  : per-channel request valid
//   gnt  : one-hot grant, combinational; first requester at or above the
//          pointer (mod NUM_CH). A grant is a transfer.
// After a transfer on channel c the pointer moves to c+1 (mod NUM_CH), so a
// channel that keeps requesting waits behind at most NUM_CH-1 others.
module proc_mem_rr_arb
  import proc_mem_arb_pkg::*;
#(
  parameter int NUM_CH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  output logic [NUM_CH-1:0] gnt
);

  localparam int PTR_W = ptr_w(NUM_CH);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] gnt_idx;
  logic             found;
  int               idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && rst && req[PTR_W'(idx)]) begin
        found              = 1'b1;
        gnt[PTR_W'(idx)]   = 1'b1;
        gnt_idx            = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (found) begin
      if (gnt_idx == PTR_W'(NUM_CH - 1)) ptr_d = '0;
      else                               ptr_d = gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end

endmodule

// File: rtl/proc_mem_arb.sv
// proc_mem_arb -- NUM_CH requesters sharing a NUM_WORDS-deep word memory.
//   clk        : clock
//   rst        : synchronous active-low reset
//   req_val    : per-channel request valid
//   req_rdy    : per-channel ready (at most one set, round-robin)
//   req_type   : per-channel type, 0 read / 1 write
//   req_addr   : per-channel byte address, packed, channel 0 in LSBs
//   req_wdata  : per-channel write data, packed
//   resp_val   : one-hot response valid, one cycle after each transfer
//   resp_rdata : read data (zero for write acknowledges / idle)
// One transfer per cycle; responses are never back-pressured.
module proc_mem_arb
  import proc_mem_arb_pkg::*;
#(
  parameter int NUM_CH    = 3,
  parameter int NUM_WORDS = 256,
  parameter int DATA_W    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          req_val,
  output logic [NUM_CH-1:0]          req_rdy,
  input  logic [NUM_CH-1:0]          req_type,
  input  logic [NUM_CH*ADDR_W-1:0]   req_addr,
  input  logic [NUM_CH*DATA_W-1:0]   req_wdata,
  output logic [NUM_CH-1:0]          resp_val,
  output logic [DATA_W-1:0]          resp_rdata
);

  localparam int IDX_W = idx_w(NUM_WORDS);

  logic [NUM_CH-1:0] gnt;
  logic              xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  req_type_e         sel_type;
  logic [IDX_W-1:0]  word_idx;

  logic [DATA_W-1:0] mem_q [NUM_WORDS];
  logic [NUM_CH-1:0] resp_val_q;
  logic [DATA_W-1:0] resp_rdata_q;

  proc_mem_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (req_val),
    .gnt (gnt)
  );

  assign req_rdy = gnt;
  assign xfer    = |gnt;

  // Grant is one-hot, so a priority-free OR-mux picks the winner's fields.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_type  = REQ_READ;
    for (int c = 0; c < NUM_CH; c++) begin
      if (gnt[c]) begin
        sel_addr  = req_addr[c*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[c*DATA_W +: DATA_W];
        sel_type  = req_type_e'(req_type[c]);
      end
    end
  end

  // Upper address bits alias (wrap) and byte offset is ignored.
  assign word_idx = sel_addr[IDX_W+BYTE_LSB-1:BYTE_LSB];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{sel_addr[ADDR_W-1:IDX_W+BYTE_LSB], sel_addr[BYTE_LSB-1:0]};

  // Storage is deliberately not reset; xfer is already blocked during reset.
  always_ff @(posedge clk) begin
    if (xfer && sel_type == REQ_WRITE) mem_q[word_idx] <= sel_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      resp_val_q   <= '0;
      resp_rdata_q <= '0;
    end else begin
      resp_val_q   <= gnt;
      resp_rdata_q <= (xfer && sel_type == REQ_READ) ? mem_q[word_idx] : '0;
    end
  end

  // A response already registered when reset arrives is dropped, not shown.
  assign resp_val   = rst ? resp_val_q   : '0;
  assign resp_rdata = rst ? resp_rdata_q : '0;

endmodule

// File: tb/tb_proc_mem_arb.sv
module tb_proc_mem_arb;

  localparam int NCH = 3;
  localparam int DW  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    req_val;
  logic [NCH-1:0]    req_rdy;
  logic [NCH-1:0]    req_type;
  logic [NCH*32-1:0] req_addr;
  logic [NCH*DW-1:0] req_wdata;
  logic [NCH-1:0]    resp_val;
  logic [DW-1:0]     resp_rdata;

  int total = 0;
  int bad   = 0;

  proc_mem_arb #(.NUM_CH(NCH), .NUM_WORDS(256), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_val    (req_val),
    .req_rdy    (req_rdy),
    .req_type   (req_type),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_val   (resp_val),
    .resp_rdata (resp_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    req_val   = '0;
    req_type  = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic set_req(input int ch, input logic typ, input logic [31:0] addr,
                         input logic [DW-1:0] wd);
    req_val[ch]          = 1'b1;
    req_type[ch]         = typ;
    req_addr[ch*32 +: 32] = addr;
    req_wdata[ch*DW +: DW] = wd;
  endtask

  task automatic pulse_reset();
    clear_all();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    clear_all();
    rst = 1'b0;
    for (int c = 0; c < NCH; c++) set_req(c, 1'b1, 32'h10, 32'h1);
    #1;
    total++;
    if (req_rdy !== 3'b000) begin
      bad++; $display("FAIL reset_rdy got=%b want=000", req_rdy);
    end
    tick();
    tick();
    total++;
    if (resp_val !== 3'b000) begin
      bad++; $display("FAIL reset_resp_val got=%b want=000", resp_val);
    end
    total++;
    if (resp_rdata !== 32'h0) begin
      bad++; $display("FAIL reset_resp_rdata got=%h want=0", resp_rdata);
    end
    clear_all();
    rst = 1'b1;
  endtask

  task automatic test_single();
    clear_all();
    set_req(0, 1'b1, 32'h10, 32'hDEADBEEF);
    #1;
    total++;
    if (req_rdy !== 3'b001) begin
      bad++; $display("FAIL single_wr_rdy got=%b want=001", req_rdy);
    end
    tick();
    clear_all();
    set_req(0, 1'b0, 32'h10, 32'h0);
    total++;
    if (resp_val !== 3'b001 || resp_rdata !== 32'h0) begin
      bad++; $display("FAIL single_wr_ack got=%b/%h want=001/0", resp_val, resp_rdata);
    end
    #1;
    total++;
    if (req_rdy !== 3'b001) begin
      bad++; $display("FAIL single_rd_rdy got=%b want=001", req_rdy);
    end
    tick();
    clear_all();
    total++;
    if (resp_val !== 3'b001 || resp_rdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL single_rd_data got=%b/%h want=001/deadbeef", resp_val, resp_rdata);
    end
    #1;
    total++;
    if (req_rdy !== 3'b000) begin
      bad++; $display("FAIL idle_rdy got=%b want=000", req_rdy);
    end
    tick();
    total++;
    if (resp_val !== 3'b000 || resp_rdata !== 32'h0) begin
      bad++; $display("FAIL idle_resp got=%b/%h want=000/0", resp_val, resp_rdata);
    end
  endtask

  task automatic test_contention();
    logic [NCH-1:0] exp_g [4];
    exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
    pulse_reset();
    for (int c = 0; c < NCH; c++) set_req(c, 1'b0, 32'h10, 32'h0);
    for (int k = 0; k < 4; k++) begin
      #1;
      total++;
      if (req_rdy !== exp_g[k]) begin
        bad++; $display("FAIL contention_gnt%0d got=%b want=%b", k, req_rdy, exp_g[k]);
      end
      tick();
      total++;
      if (resp_val !== exp_g[k] || resp_rdata !== 32'hDEADBEEF) begin
        bad++; $display("FAIL contention_resp%0d got=%b/%h want=%b/deadbeef",
                        k, resp_val, resp_rdata, exp_g[k]);
      end
    end
    clear_all();
    tick();
  endtask

  task automatic test_back_to_back();
    clear_all();
    set_req(1, 1'b1, 32'h20, 32'h5);
    #1;
    total++;
    if (req_rdy !== 3'b010) begin
      bad++; $display("FAIL b2b_wr_rdy got=%b want=010", req_rdy);
    end
    tick();
    clear_all();
    set_req(1, 1'b0, 32'h20, 32'h0);
    #1;
    total++;
    if (req_rdy !== 3'b010) begin
      bad++; $display("FAIL b2b_rd_rdy got=%b want=010", req_rdy);
    end
    tick();
    clear_all();
    total++;
    if (resp_val !== 3'b010 || resp_rdata !== 32'h5) begin
      bad++; $display("FAIL b2b_rd_data got=%b/%h want=010/5", resp_val, resp_rdata);
    end
  endtask

  task automatic test_wrap();
    clear_all();
    set_req(0, 1'b1, 32'h400, 32'hA5);
    tick();
    clear_all();
    set_req(0, 1'b0, 32'h000, 32'h0);
    tick();
    clear_all();
    total++;
    if (resp_val !== 3'b001 || resp_rdata !== 32'hA5) begin
      bad++; $display("FAIL wrap_rd got=%b/%h want=001/a5", resp_val, resp_rdata);
    end
  endtask

  task automatic test_mid_reset();
    clear_all();
    set_req(1, 1'b1, 32'h30, 32'h1234);
    tick();
    clear_all();
    set_req(1, 1'b0, 32'h30, 32'h0);
    tick();
    // read on ch1 just transferred; pointer now 2, response pending
    clear_all();
    rst = 1'b0;
    #1;
    total++;
    if (resp_val !== 3'b000 || resp_rdata !== 32'h0) begin
      bad++; $display("FAIL midrst_drop got=%b/%h want=000/0", resp_val, resp_rdata);
    end
    tick();
    rst = 1'b1;
    total++;
    if (resp_val !== 3'b000) begin
      bad++; $display("FAIL midrst_after got=%b want=000", resp_val);
    end
    for (int c = 0; c < NCH; c++) set_req(c, 1'b0, 32'h30, 32'h0);
    #1;
    total++;
    if (req_rdy !== 3'b001) begin
      bad++; $display("FAIL midrst_ptr got=%b want=001", req_rdy);
    end
    tick();
    clear_all();
    total++;
    if (resp_val !== 3'b001 || resp_rdata !== 32'h1234) begin
      bad++; $display("FAIL midrst_keep got=%b/%h want=001/1234", resp_val, resp_rdata);
    end
  endtask

  task automatic test_sparse();
    pulse_reset();
    set_req(2, 1'b0, 32'h20, 32'h0);
    #1;
    total++;
    if (req_rdy !== 3'b100) begin
      bad++; $display("FAIL sparse_gnt got=%b want=100", req_rdy);
    end
    tick();
    clear_all();
    total++;
    if (resp_val !== 3'b100 || resp_rdata !== 32'h5) begin
      bad++; $display("FAIL sparse_resp got=%b/%h want=100/5", resp_val, resp_rdata);
    end
    for (int c = 0; c < NCH; c++) set_req(c, 1'b0, 32'h0, 32'h0);
    #1;
    total++;
    if (req_rdy !== 3'b001) begin
      bad++; $display("FAIL sparse_ptr got=%b want=001", req_rdy);
    end
    tick();
    clear_all();
  endtask

  initial begin
    rst = 1'b0;
    clear_all();
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_wrap();
    test_mid_reset();
    test_sparse();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule

// File: doc/proc_mem_arb.md
PROC_MEM_ARB -- requirements
Module: proc_mem_arb

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, number of requester channels (1..8).
REQ-002 SHALL have parameter NUM_WORDS, default 256, 32-bit words of internal storage (power of two, >=2).
REQ-003 SHALL have parameter DATA_W, default 32, data width; address width fixed at 32.
REQ-004 SHALL have port clk  input  1  the single clock.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port req_val  input  NUM_CH  per-channel request valid.
REQ-007 SHALL have port req_rdy  output  NUM_CH  per-channel request ready, at most one bit set.
REQ-008 SHALL have port req_type  input  NUM_CH  per-channel type, 0 read, 1 write.
REQ-009 SHALL have port req_addr  input  NUM_CH*32  per-channel byte address, packed, channel 0 in LSBs.
REQ-010 SHALL have port req_wdata  input  NUM_CH*DATA_W  per-channel write data, packed.
REQ-011 SHALL have port resp_val  output  NUM_CH  one-hot response valid, identifies the channel.
REQ-012 SHALL have port resp_rdata  output  DATA_W  shared response data, qualified by resp_val.

Function
REQ-013 SHALL transfer a request on channel c in a cycle where req_val[c] and req_rdy[c] are both 1.
REQ-014 SHALL set req_rdy[c] combinationally: 1 only for the first channel with req_val set, searching from priority pointer P upward modulo NUM_CH.
REQ-015 SHALL drive req_rdy all-zero when req_val is all-zero.
REQ-016 SHALL advance P to (c+1) mod NUM_CH after a transfer on c; P SHALL hold when no transfer occurs.
REQ-017 SHALL index storage with req_addr[log2(NUM_WORDS)+1:2]; upper and lower-two bits ignored (wrap modulo NUM_WORDS words).
REQ-018 SHALL, on a write transfer, update the addressed word at the clock edge ending the transfer cycle.
REQ-019 SHALL assert resp_val[c] exactly one cycle after every transfer on c, for one cycle.
REQ-020 SHALL return the addressed word on resp_rdata for a read; zero for a write acknowledge.
REQ-021 SHALL return newly written data to a read transferred the cycle after a write to the same word.
REQ-022 SHALL drive resp_val all-zero and resp_rdata zero in cycles following no transfer.
REQ-023 SHALL grant any continuously-valid channel within NUM_CH transfers (no starvation).
REQ-024 SHALL accept one transfer per cycle at full throughput; responses have no backpressure.

Reset
REQ-025 SHALL, while rst is 0 at a clock edge, set P to 0, resp_val to 0, resp_rdata to 0.
REQ-026 SHALL drive req_rdy all-zero while rst is 0; no transfer or write occurs in a reset cycle.
REQ-027 SHALL drop responses pending when reset is asserted mid-operation; storage contents are not reset.

Structure
REQ-028 SHALL place the req type encoding (READ=0, WRITE=1) and parameter-derived widths in package proc_mem_arb_pkg.
REQ-029 SHALL implement the round-robin grant and pointer in sub-module proc_mem_rr_arb, parameterised by NUM_CH.

Verification
REQ-030 SHALL test single channel: ch0 write 0xDEADBEEF to 0x10, then read 0x10 -> resp_val=3'b001 one cycle later each, read data 0xDEADBEEF.
REQ-031 SHALL test contention: all 3 channels valid continuously from reset -> grants ch0,ch1,ch2,ch0 on consecutive cycles.
REQ-032 SHALL test back-to-back: ch1 write 0x5 to 0x20, ch1 read 0x20 next cycle -> read returns 0x5.
REQ-033 SHALL test wrap: NUM_WORDS=256, write 0xA5 to 0x400, read 0x000 -> returns 0xA5.
REQ-034 SHALL test mid-operation reset: rst=0 the cycle after a read transfer -> resp_val 0, P=0; data written before reset still readable afterward.
REQ-035 SHALL test sparse requests: ch2 only valid, P=0 -> ch2 granted same cycle, P becomes 0.
